// File: rtl/mynios2_interval_timer_if.sv
// ============================================================================
// Module   : mynios2_interval_timer_if
// Purpose  : Avalon-MM slave bus bundle for the mynios2 interval timer.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface mynios2_interval_timer_if;
   logic        chipselect;
   logic        write_n;
   logic [2:0]  address;
   logic [15:0] writedata;
   logic [15:0] readdata;

   modport master (
      output chipselect,
      output write_n,
      output address,
      output writedata,
      input  readdata
   );

   modport slave (
      input  chipselect,
      input  write_n,
      input  address,
      input  writedata,
      output readdata
   );
endinterface

`default_nettype wire

// File: rtl/mynios2_interval_timer.sv
// ============================================================================
// Module   : mynios2_interval_timer
// Purpose  : Avalon-MM interval timer with programmable period, start/stop,
//            continuous/one-shot modes; optional counter snapshot enabled by
//            defining MYNIOS2_TIMER_SNAPSHOT_EN.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mynios2_interval_timer #(
   parameter int unsigned COUNTER_WIDTH  = 32,
   parameter logic [31:0] DEFAULT_PERIOD = 32'h0007A11F,
   parameter bit          START_ON_RESET = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   mynios2_interval_timer_if.slave bus,
   output logic                   irq,
   output logic                   timeout_pulse
);

   localparam int unsigned    CW           = COUNTER_WIDTH;
   localparam logic [CW-1:0]  RESET_PERIOD = DEFAULT_PERIOD[CW-1:0];
   localparam logic [CW-1:0]  COUNT_ONE    = {{(CW-1){1'b0}}, 1'b1};

   localparam logic [2:0] ADDR_STATUS  = 3'd0;
   localparam logic [2:0] ADDR_CONTROL = 3'd1;
   localparam logic [2:0] ADDR_PERIODL = 3'd2;
   localparam logic [2:0] ADDR_PERIODH = 3'd3;
   localparam logic [2:0] ADDR_SNAPL   = 3'd4;
   localparam logic [2:0] ADDR_SNAPH   = 3'd5;

   logic [CW-1:0] period;
   logic [CW-1:0] counter;
   logic [CW-1:0] period_next;
   logic [31:0]   period_ext;
   logic [31:0]   period_wr;
   logic          run;
   logic          cont;
   logic          ito;
   logic          to;
   logic          timeout_event;
   logic          event_now;
   logic          write;
   logic          status_write;
   logic          control_write;
   logic          period_write;
   logic [15:0]   read_mux;

   assign write         = bus.chipselect && !bus.write_n;
   assign status_write  = write && (bus.address == ADDR_STATUS);
   assign control_write = write && (bus.address == ADDR_CONTROL);
   assign period_write  = write && ((bus.address == ADDR_PERIODL) ||
                                    (bus.address == ADDR_PERIODH));
   assign event_now     = run && (counter == '0);
   assign period_ext    = 32'(period);
   assign irq           = to && ito;

   // Merge the written half into the full period; excess PERIODH bits drop off.
   always_comb begin
      period_wr = period_ext;
      if (bus.address == ADDR_PERIODL) begin
         period_wr[15:0] = bus.writedata;
      end else begin
         period_wr[31:16] = bus.writedata;
      end
      period_next = period_wr[CW-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period        <= RESET_PERIOD;
         counter       <= RESET_PERIOD;
         run           <= START_ON_RESET;
         cont          <= START_ON_RESET;
         ito           <= 1'b0;
         to            <= 1'b0;
         timeout_event <= 1'b0;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_event <= event_now;
         timeout_pulse <= timeout_event;

         if (period_write) begin
            period  <= period_next;
            counter <= period_next;
         end else if (run) begin
            counter <= event_now ? period : (counter - COUNT_ONE);
         end

         // A period write always parks the timer; STOP beats START.
         if (period_write) begin
            run <= 1'b0;
         end else if (control_write && bus.writedata[3]) begin
            run <= 1'b0;
         end else if (control_write && bus.writedata[2]) begin
            run <= 1'b1;
         end else if (event_now && !cont) begin
            run <= 1'b0;
         end

         if (control_write) begin
            ito  <= bus.writedata[0];
            cont <= bus.writedata[1];
         end

         if (event_now) begin
            to <= 1'b1;
         end else if (status_write) begin
            to <= 1'b0;
         end
      end
   end

`ifdef MYNIOS2_TIMER_SNAPSHOT_EN
   logic [CW-1:0] snapshot;
   logic [31:0]   snap_ext;

   assign snap_ext = 32'(snapshot);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         snapshot <= '0;
      end else if (write && ((bus.address == ADDR_SNAPL) ||
                             (bus.address == ADDR_SNAPH))) begin
         snapshot <= counter;
      end
   end
`endif

   always_comb begin
      read_mux = 16'h0000;
      case (bus.address)
         ADDR_STATUS:  read_mux = {14'b0, run, to};
         ADDR_CONTROL: read_mux = {14'b0, cont, ito};
         ADDR_PERIODL: read_mux = period_ext[15:0];
         ADDR_PERIODH: read_mux = period_ext[31:16];
`ifdef MYNIOS2_TIMER_SNAPSHOT_EN
         ADDR_SNAPL:   read_mux = snap_ext[15:0];
         ADDR_SNAPH:   read_mux = snap_ext[31:16];
`endif
         default:      read_mux = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.readdata <= 16'h0000;
      end else begin
         bus.readdata <= read_mux;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mynios2_interval_timer.sv
// ============================================================================
// Module   : tb_mynios2_interval_timer
// Purpose  : Scoreboard bench for mynios2_interval_timer with directed vectors.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mynios2_interval_timer;

   localparam int K_READ  = 0;
   localparam int K_IRQ   = 1;
   localparam int K_PULSE = 2;

   typedef struct {
      int          kind;
      int          due;
      logic [15:0] exp;
      string       name;
   } item_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic irq;
   logic timeout_pulse;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   item_t sb[$];

   mynios2_interval_timer_if bus ();

   mynios2_interval_timer dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .bus           (bus),
      .irq           (irq),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   // cyc equals the number of the most recent rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_at(input int kind, input int due, input logic [15:0] exp,
                            input string name);
      item_t it;
      it.kind = kind;
      it.due  = due;
      it.exp  = exp;
      it.name = name;
      sb.push_back(it);
   endtask

   // Called at a falling edge; the write is sampled by the next rising edge.
   task automatic bus_write(input logic [2:0] a, input logic [15:0] d, output int edge_no);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.address    = a;
      bus.writedata  = d;
      @(negedge clk);
      edge_no        = cyc;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, input logic [15:0] exp, input string name);
      bus.address = a;
      expect_at(K_READ, cyc + 1, exp, name);
      @(negedge clk);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due <= cyc) begin
            logic [15:0] act;
            case (sb[i].kind)
               K_READ:  act = bus.readdata;
               K_IRQ:   act = {15'b0, irq};
               default: act = {15'b0, timeout_pulse};
            endcase
            vectors = vectors + 1;
            if (sb[i].due < cyc) begin
               miscompares = miscompares + 1;
               $display("FAIL %s: sampled late at cycle %0d, due %0d", sb[i].name, cyc, sb[i].due);
            end else if (act !== sb[i].exp) begin
               miscompares = miscompares + 1;
               $display("FAIL %s: got %h expected %h (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
            end
            sb.delete(i);
         end
      end
   end

   initial begin
      int t;
      int s;
      int w;
      int tmp;
      logic [15:0] snap_lo;

      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.address    = 3'd0;
      bus.writedata  = 16'h0000;
      reset_n        = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      bus_read(3'd0, 16'h0000, "status out of reset");
      bus_read(3'd1, 16'h0000, "control out of reset");

      // Continuous mode, period 9: events at T+10, T+20, ...
      bus_write(3'd2, 16'd9, tmp);
      bus_write(3'd3, 16'd0, tmp);
      bus_write(3'd1, 16'h0007, t);
      expect_at(K_IRQ,   t + 9,  16'd0, "irq before first event");
      expect_at(K_IRQ,   t + 10, 16'd1, "irq after first event");
      expect_at(K_PULSE, t + 10, 16'd0, "pulse not yet");
      expect_at(K_PULSE, t + 11, 16'd1, "pulse 1");
      expect_at(K_PULSE, t + 12, 16'd0, "pulse one cycle wide");
      expect_at(K_PULSE, t + 21, 16'd1, "pulse 2");
      expect_at(K_PULSE, t + 31, 16'd1, "pulse 3");
      expect_at(K_IRQ,   t + 14, 16'd0, "irq cleared by status write");
      expect_at(K_IRQ,   t + 19, 16'd0, "irq stays cleared");
      expect_at(K_IRQ,   t + 20, 16'd1, "irq re-raised");
      expect_at(K_IRQ,   t + 30, 16'd1, "irq after collision write");
      expect_at(K_IRQ,   t + 40, 16'd1, "irq before reset");
      expect_at(K_PULSE, t + 40, 16'd0, "pulse idle before reset");
      wait_until(t + 13);
      bus_write(3'd0, 16'h0000, tmp);
      wait_until(t + 29);
      bus_write(3'd0, 16'hFFFF, tmp);
      bus_read(3'd0, 16'h0003, "status after collision");

      // Mid-cycle reset while irq is high and a pulse is due.
      wait_until(t + 40);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      expect_at(K_IRQ,   cyc, 16'd0, "irq async reset");
      expect_at(K_PULSE, cyc, 16'd0, "pulse async reset");
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      bus_read(3'd0, 16'h0000, "reset STATUS");
      bus_read(3'd1, 16'h0000, "reset CONTROL");
      bus_read(3'd2, 16'hA11F, "reset PERIODL");
      bus_read(3'd3, 16'h0007, "reset PERIODH");
      bus_read(3'd4, 16'h0000, "reset SNAPL");
      bus_read(3'd5, 16'h0000, "reset SNAPH");
      bus_read(3'd6, 16'h0000, "reset addr6");
      bus_read(3'd7, 16'h0000, "reset addr7");

      // One-shot, period 4: single event at T+5.
      bus_write(3'd2, 16'd4, tmp);
      bus_write(3'd3, 16'd0, tmp);
      bus_write(3'd1, 16'h0005, t);
      expect_at(K_PULSE, t + 5, 16'd0, "oneshot pulse early");
      expect_at(K_PULSE, t + 6, 16'd1, "oneshot pulse");
      expect_at(K_IRQ,   t + 6, 16'd1, "oneshot irq");
      for (int i = 7; i < 57; i++) expect_at(K_PULSE, t + i, 16'd0, "oneshot no repeat");
      wait_until(t + 58);
      bus_read(3'd0, 16'h0001, "oneshot status");
      // Counter was left at 4, so a restart times out after 5 cycles again.
      bus_write(3'd1, 16'h0005, t);
      expect_at(K_PULSE, t + 5, 16'd0, "oneshot restart early");
      expect_at(K_PULSE, t + 6, 16'd1, "oneshot restart pulse");
      wait_until(t + 10);

      // START and STOP together: STOP wins.
      bus_write(3'd1, 16'h0006, tmp);
      bus_write(3'd1, 16'h000C, tmp);
      bus_write(3'd0, 16'h0000, tmp);
      bus_read(3'd0, 16'h0000, "start|stop status");
      bus_read(3'd1, 16'h0000, "start|stop control");

      // Period write mid-count parks the timer at the new period.
      bus_write(3'd2, 16'd100, tmp);
      bus_write(3'd1, 16'h0006, t);
      wait_until(t + 30);
      bus_write(3'd2, 16'd20, w);
      bus_read(3'd0, 16'h0000, "status after period write");
      bus_read(3'd2, 16'd20, "PERIODL after period write");
      wait_until(w + 10);
      bus_write(3'd1, 16'h0006, s);
      expect_at(K_PULSE, s + 21, 16'd0, "period20 pulse early");
      expect_at(K_PULSE, s + 22, 16'd1, "period20 first pulse");
      wait_until(s + 23);
      bus_write(3'd1, 16'h0008, tmp);

      // Snapshot at edge T+50 of a 1000-cycle count captures 1000-49.
`ifdef MYNIOS2_TIMER_SNAPSHOT_EN
      snap_lo = 16'h03B7;
`else
      snap_lo = 16'h0000;
`endif
      bus_write(3'd2, 16'd1000, tmp);
      bus_write(3'd1, 16'h0006, t);
      wait_until(t + 49);
      bus_write(3'd4, 16'hBEEF, tmp);
      bus_read(3'd4, snap_lo, "SNAPL");
      bus_read(3'd5, 16'h0000, "SNAPH");
      expect_at(K_PULSE, t + 1001, 16'd0, "snapshot run pulse early");
      expect_at(K_PULSE, t + 1002, 16'd1, "snapshot run pulse");
      wait_until(t + 1003);

      for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         $display("FAIL scoreboard drain: %0d expectations never sampled, expected 0", sb.size());
         vectors     = vectors + sb.size();
         miscompares = miscompares + sb.size();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
